// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types and constants for the OTTER memory arbiter
//   state_t (IDLE/BUSY/RESP), gnt_t (GNT_I/GNT_D), size_t (SZ_B/SZ_H/SZ_W),
//   ERR_DATA returned on a timed-out access, TIMEOUT_DEF default ack budget.
package otter_mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {GNT_I, GNT_D} gnt_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
   localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: fetch, data and memory handshakes of the OTTER memory arbiter
//   i_*: fetch port, d_*: load/store port, m_*: shared memory port, err/busy: status.
//   slave: the arbiter; master: the control unit plus memory around it.
interface otter_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              i_req, i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req, d_we, d_valid;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic              m_req, m_we, m_ack;
   logic [1:0]        m_size;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic              err, busy;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_valid, d_rdata, d_valid, m_req, m_we, m_size, m_addr, m_wdata, err, busy
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_valid, d_rdata, d_valid, m_req, m_we, m_size, m_addr, m_wdata, err, busy
   );
endinterface

// File: rtl/otter_mem_wdt.sv
// otter_mem_wdt: ack timeout counter for the OTTER memory arbiter
//   clr: restart at zero, en: count one waiting cycle, expired: this waiting cycle is the last allowed.
import otter_mem_pkg::*;
module otter_mem_wdt #(parameter int TIMEOUT = TIMEOUT_DEF) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt;
   // fires in the cycle whose increment would bring the count to TIMEOUT
   assign expired = en && cnt == W'(TIMEOUT - 1);
   always_ff @(posedge clk)
      cnt <= rst || clr ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one variable-latency memory between fetch and load/store ports
//   clk, rst (sync, active-high); bus: otter_mem_arbiter_if.slave carrying fetch/data
//   request-valid handshakes, memory req/ack handshake, err and busy.
//   Optional ack timeout with ERR_DATA response when OTTER_MEM_TIMEOUT_EN is defined.
import otter_mem_pkg::*;
module otter_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic clk,
   input logic rst,
   otter_mem_arbiter_if.slave bus
);
   state_t            state;
   gnt_t              gnt, last_grant, pick;
   logic              grant, done;
   logic [DATA_W-1:0] resp_data;
   assign grant = state == IDLE && (bus.i_req || bus.d_req);
   // on a tie the port not granted last wins
   assign pick = bus.i_req && bus.d_req ? (last_grant == GNT_I ? GNT_D : GNT_I)
               : bus.d_req ? GNT_D : GNT_I;
`ifdef OTTER_MEM_TIMEOUT_EN
   logic expired, err_r;
   otter_mem_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk(clk), .rst(rst), .clr(grant), .en(state == BUSY && !bus.m_ack), .expired(expired)
   );
   assign done      = state == BUSY && (bus.m_ack || expired);
   assign resp_data = bus.m_ack ? bus.m_rdata : DATA_W'(ERR_DATA);
   assign bus.err   = err_r;
   // set only on leaving BUSY without ack, so it is high exactly in that RESP cycle
   always_ff @(posedge clk)
      err_r <= !rst && done && !bus.m_ack;
`else
   assign done      = state == BUSY && bus.m_ack;
   assign resp_data = bus.m_rdata;
   assign bus.err   = 1'b0;
`endif
   assign bus.m_req   = state == BUSY;
   assign bus.i_valid = state == RESP && gnt == GNT_I;
   assign bus.d_valid = state == RESP && gnt == GNT_D;
   assign bus.busy    = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= GNT_I;
         last_grant  <= GNT_I;
         bus.m_we    <= 1'b0;
         bus.m_size  <= SZ_B;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.i_rdata <= '0;
         bus.d_rdata <= '0;
      end else begin
         state <= grant ? BUSY : done ? RESP : state == RESP ? IDLE : state;
         if (grant) begin
            gnt         <= pick;
            last_grant  <= pick;
            bus.m_we    <= pick == GNT_D && bus.d_we;
            bus.m_size  <= pick == GNT_D ? bus.d_size : SZ_W;
            bus.m_addr  <= pick == GNT_D ? bus.d_addr : bus.i_addr;
            bus.m_wdata <= pick == GNT_D ? bus.d_wdata : '0;
         end
         if (done && gnt == GNT_I) bus.i_rdata <= resp_data;
         if (done && gnt == GNT_D && !bus.m_we) bus.d_rdata <= resp_data;
      end
   end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: self-checking bench for otter_mem_arbiter (vector table + response scoreboard)
module tb_otter_mem_arbiter;
   import otter_mem_pkg::*;
   typedef struct {
      bit          d;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr, wdata, rdata;
      int          lat;
   } vec_t;
   typedef struct {
      bit          port_d;
      logic [31:0] rdata;
      bit          err;
   } resp_t;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, errors = 0;
   logic [31:0] exp_i = '0, exp_d = '0;
   resp_t sb[$];
   vec_t vt[8];
   always #5 clk = ~clk;
   otter_mem_arbiter_if bus ();
   otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic push(input bit d, input logic [31:0] r, input bit we, input bit e);
      resp_t x;
      if (d && !we) exp_d = r;
      if (!d) exp_i = r;
      x.port_d = d;
      x.rdata  = d ? exp_d : exp_i;
      x.err    = e;
      sb.push_back(x);
   endtask
   // valid pulses are matched in order against the scoreboard
   always @(negedge clk) begin
      resp_t e;
      if (bus.i_valid && bus.d_valid) chk("dual_valid", 1, 0);
      else if (bus.i_valid || bus.d_valid) begin
         if (sb.size() == 0) chk("unexpected_valid", {bus.i_valid, bus.d_valid}, 0);
         else begin
            e = sb.pop_front();
            chk("valid_port", bus.d_valid, e.port_d);
            chk("resp_rdata", e.port_d ? bus.d_rdata : bus.i_rdata, e.rdata);
            chk("resp_err", bus.err, e.err);
         end
      end else chk("err_idle", bus.err, 0);
   end
   task automatic do_reset;
      rst = 1'b1;
      bus.i_req = 0; bus.d_req = 0; bus.m_ack = 0;
      tick;
      tick;
      rst = 1'b0;
      exp_i = '0;
      exp_d = '0;
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_m_req"}, bus.m_req, 0);
      chk({tag, "_m_we"}, bus.m_we, 0);
      chk({tag, "_m_addr"}, bus.m_addr, 0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 0);
      chk({tag, "_m_size"}, bus.m_size, 0);
      chk({tag, "_i_rdata"}, bus.i_rdata, 0);
      chk({tag, "_d_rdata"}, bus.d_rdata, 0);
      chk({tag, "_valids"}, {bus.i_valid, bus.d_valid}, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask
   task automatic access(input vec_t v);
      if (v.d) begin
         bus.d_req = 1; bus.d_we = v.we; bus.d_size = v.size; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.i_req = 1; bus.i_addr = v.addr;
      end
      tick;
      for (int c = 1; c <= v.lat; c++) begin
         chk("busy_m_req", bus.m_req, 1);
         chk("busy_m_addr", bus.m_addr, v.addr);
         chk("busy_m_we", bus.m_we, v.d && v.we);
         chk("busy_m_size", bus.m_size, v.d ? v.size : 2'b10);
         if (v.d && v.we) chk("busy_m_wdata", bus.m_wdata, v.wdata);
         // request fields wander during BUSY and must not leak into m_*
         if (v.d) begin bus.d_addr = $urandom; bus.d_wdata = $urandom; end
         else bus.i_addr = $urandom;
         if (c == v.lat) begin
            bus.m_ack = 1; bus.m_rdata = v.rdata;
            push(v.d, v.rdata, v.we, 0);
         end else bus.m_rdata = $urandom;
         tick;
      end
      bus.m_ack = 0; bus.i_req = 0; bus.d_req = 0;
      chk("resp_valid", v.d ? bus.d_valid : bus.i_valid, 1);
      chk("resp_m_req", bus.m_req, 0);
      chk("resp_busy", bus.busy, 1);
      tick;
      chk("idle_busy", bus.busy, 0);
      chk("idle_valids", {bus.i_valid, bus.d_valid}, 0);
   endtask
   task automatic tie(input bit first_d);
      bit d;
      logic [31:0] r;
      bus.i_req = 1; bus.i_addr = 32'h200;
      bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h7000;
      for (int k = 0; k < 2; k++) begin
         d = k == 0 ? first_d : !first_d;
         tick;
         chk("tie_m_req", bus.m_req, 1);
         chk("tie_order", bus.m_addr, d ? 32'h7000 : 32'h200);
         chk("tie_m_we", bus.m_we, 0);
         r = 32'h7E00_0000 + 32'(k) + (first_d ? 32'h10 : 32'h0);
         bus.m_ack = 1; bus.m_rdata = r;
         push(d, r, 0, 0);
         tick;
         bus.m_ack = 0;
         if (d) bus.d_req = 0; else bus.i_req = 0;
         chk("tie_valid", d ? bus.d_valid : bus.i_valid, 1);
         tick;
         chk("tie_idle", bus.busy, 0);
      end
   endtask
   initial begin
      int n;
      vt[0] = '{0, 0, 2'b10, 32'h0000_0100, 32'h0, 32'h0050_0093, 3};
      vt[1] = '{1, 1, 2'b10, 32'h0000_6000, 32'hA5A5_A5A5, 32'h1234_5678, 4};
      vt[2] = '{1, 0, 2'b00, 32'h0000_6001, 32'h0, 32'h0000_00A5, 1};
      vt[3] = '{1, 0, 2'b01, 32'h0000_6002, 32'h0, 32'h0000_BEEF, 2};
      vt[4] = '{0, 0, 2'b10, 32'h0000_0104, 32'h0, 32'h0000_0013, 1};
      vt[5] = '{1, 1, 2'b01, 32'h0000_6010, 32'h0000_5A5A, 32'hFFFF_FFFF, 2};
      vt[6] = '{1, 0, 2'b10, 32'h0000_6020, 32'h0, 32'hCAFE_F00D, 5};
      vt[7] = '{0, 0, 2'b10, 32'h0000_0108, 32'h0, 32'h00A0_0113, 6};
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_size = '0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.m_ack = 0; bus.m_rdata = '0;
      do_reset;
      chk_reset_vals("reset");
      for (int i = 0; i < 8; i++) access(vt[i]);
      // first tie after reset goes to D, then I in the following IDLE cycle
      do_reset;
      tie(1);
      access(vt[2]);
      tie(0);
      // reset in the second BUSY cycle discards the access
      bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h8000;
      tick;
      tick;
      rst = 1'b1;
      tick;
      chk_reset_vals("rst_busy");
      rst = 1'b0; bus.d_req = 0; exp_i = '0; exp_d = '0;
      tick;
      tick;
      chk("rst_busy_after", bus.busy, 0);
      // back-to-back loads with immediate ack and d_req held throughout
      bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10;
      for (int c = 0; c < 12; c++) begin
         chk("b2b_m_req", bus.m_req, c % 3 == 1);
         chk("b2b_d_valid", bus.d_valid, c % 3 == 2);
         if (c % 3 != 0) chk("b2b_m_addr", bus.m_addr, 32'h9000 + 32'((c - c % 3) * 4));
         bus.d_addr = 32'h9000 + 32'(c * 4);
         bus.m_ack = c % 3 == 1;
         bus.m_rdata = 32'hC0DE_0000 + 32'(c);
         if (c % 3 == 1) push(1, 32'hC0DE_0000 + 32'(c), 0, 0);
         if (c == 11) bus.d_req = 0;
         tick;
      end
      bus.m_ack = 0;
      chk("b2b_end_busy", bus.busy, 0);
      tick;
      chk("b2b_end_idle", bus.busy, 0);
`ifdef OTTER_MEM_TIMEOUT_EN
      bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'hA000;
      push(1, ERR_DATA, 0, 1);
      tick;
      n = 0;
      while (bus.m_req && n < 40) begin
         n++;
         tick;
      end
      chk("timeout_busy_cycles", n, 15);
      bus.d_req = 0;
      chk("timeout_valid", bus.d_valid, 1);
      chk("timeout_err", bus.err, 1);
      tick;
      chk("timeout_idle", bus.busy, 0);
`else
      n = 0;
`endif
      tick;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
